// File: rtl/text_pkg.sv
// Shared definitions for the text console: screen geometry, control codes,
// FSM state encoding and the row/column to VRAM address mapping.
package text_pkg;

   localparam int TEXT_COLS = 100;
   localparam int TEXT_ROWS = 30;
   localparam int VRAM_AW   = 12;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_FF    = 8'h0C;

   typedef enum logic [1:0] {
      CLEAR_ALL = 2'd0,
      IDLE      = 2'd1,
      SCROLL    = 2'd2,
      CLEAR_ROW = 2'd3
   } text_state_e;

   // Row-major VRAM address; the largest result (2999) fits in 12 bits.
   function automatic logic [VRAM_AW-1:0] text_addr(input logic [4:0] y,
                                                    input logic [6:0] x,
                                                    input int         cols);
      text_addr = VRAM_AW'(y) * VRAM_AW'(cols) + VRAM_AW'(x);
   endfunction

endpackage

// File: rtl/text_console_writer_cursor_blinker.sv
// Cursor blink generator: toggles every BLINK_DIV cycles, and a restart
// pulse makes the cursor visible again with a fresh half-period.
module cursor_blinker #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic restart_i,
   output logic blink_o
);

   localparam int             CW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          blink_q;

   // Half-period counter and visibility toggle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         blink_q <= 1'b1;
      end else if (restart_i) begin
         cnt_q   <= '0;
         blink_q <= 1'b1;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q   <= '0;
         blink_q <= ~blink_q;
      end else begin
         cnt_q   <= cnt_q + 1'b1;
      end
   end

   assign blink_o = blink_q;

endmodule

// File: rtl/text_console_writer.sv
// Write-side terminal engine: interprets an ASCII byte stream, writes glyphs
// into the text VRAM, scrolls by copying rows up through the second VRAM
// port, and drives the cursor position/blink seen by the display.
module text_console_writer
   import text_pkg::*;
#(
   parameter int COLS      = TEXT_COLS,
   parameter int ROWS      = TEXT_ROWS,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               char_valid_i,
   input  logic [7:0]         char_data_i,
   output logic               char_ready_o,
   output logic               vram_we_o,
   output logic [VRAM_AW-1:0] vram_waddr_o,
   output logic [7:0]         vram_wdata_o,
   output logic [VRAM_AW-1:0] vram_raddr_o,
   input  logic [7:0]         vram_rdata_i,
   output logic [6:0]         cursor_x_o,
   output logic [4:0]         cursor_y_o,
   output logic               cursor_blink_o
);

   localparam logic [6:0]         X_LAST    = 7'(COLS - 1);
   localparam logic [4:0]         Y_LAST    = 5'(ROWS - 1);
   localparam logic [VRAM_AW-1:0] COLS_A    = VRAM_AW'(COLS);
   localparam logic [VRAM_AW-1:0] CLR_LAST  = VRAM_AW'(COLS * ROWS - 1);
   // Scroll runs one extra cycle past the last read to drain the final write.
   localparam logic [VRAM_AW-1:0] SCR_LAST  = VRAM_AW'(COLS * (ROWS - 1));
   localparam logic [VRAM_AW-1:0] ROW_LAST  = VRAM_AW'(COLS - 1);
   localparam logic [VRAM_AW-1:0] LAST_BASE = VRAM_AW'(COLS * (ROWS - 1));

   text_state_e        state_q, state_d;
   logic [VRAM_AW-1:0] idx_q, idx_d;
   logic               ready_q, ready_d;
   logic               we_q, we_d;
   logic [VRAM_AW-1:0] waddr_q, waddr_d;
   logic [7:0]         wdata_q, wdata_d;
   logic [VRAM_AW-1:0] raddr_q, raddr_d;
   logic [6:0]         cx_q, cx_d;
   logic [4:0]         cy_q, cy_d;

   logic               accept;
   logic               is_print;
   logic               newline;
   logic [VRAM_AW-1:0] cur_addr;

   assign accept   = char_valid_i & ready_q;
   assign is_print = (char_data_i >= 8'h20) && (char_data_i <= 8'h7E);
   assign newline  = accept && ((is_print && (cx_q == X_LAST)) || (char_data_i == ASCII_LF));
   assign cur_addr = text_addr(cy_q, cx_q, COLS);

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= CLEAR_ALL;
         idx_q   <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= ASCII_SPACE;
         raddr_q <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         raddr_q <= raddr_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
      end
   end

   // Next-state decision
   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR_ALL: if (idx_q == CLR_LAST) state_d = IDLE;
         IDLE: begin
            if (accept && (char_data_i == ASCII_FF)) state_d = CLEAR_ALL;
            else if (newline && (cy_q == Y_LAST))    state_d = SCROLL;
         end
         SCROLL:    if (idx_q == SCR_LAST) state_d = CLEAR_ROW;
         CLEAR_ROW: if (idx_q == ROW_LAST) state_d = IDLE;
         default:   state_d = CLEAR_ALL;
      endcase
   end

   // Next values for VRAM ports, cursor and the shared sweep index
   always_comb begin
      idx_d   = idx_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      raddr_d = raddr_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      case (state_q)
         CLEAR_ALL: begin
            we_d    = 1'b1;
            waddr_d = idx_q;
            wdata_d = ASCII_SPACE;
            idx_d   = idx_q + 1'b1;
         end
         SCROLL: begin
            // Read address leads the write address by one cycle; the
            // word returned for step idx-1 is written while idx is issued.
            if (idx_q < SCR_LAST - 1'b1) raddr_d = raddr_q + 1'b1;
            if (idx_q != '0) begin
               we_d    = 1'b1;
               waddr_d = idx_q - 1'b1;
               wdata_d = vram_rdata_i;
            end
            idx_d = idx_q + 1'b1;
         end
         CLEAR_ROW: begin
            we_d    = 1'b1;
            waddr_d = LAST_BASE + idx_q;
            wdata_d = ASCII_SPACE;
            idx_d   = idx_q + 1'b1;
         end
         default: begin
            if (accept) begin
               if (is_print) begin
                  we_d    = 1'b1;
                  waddr_d = cur_addr;
                  wdata_d = char_data_i;
                  if (cx_q != X_LAST) cx_d = cx_q + 1'b1;
               end else if (char_data_i == ASCII_CR) begin
                  cx_d = '0;
               end else if (char_data_i == ASCII_BS) begin
                  if (cx_q != '0) begin
                     cx_d    = cx_q - 1'b1;
                     we_d    = 1'b1;
                     waddr_d = cur_addr - 1'b1;
                     wdata_d = ASCII_SPACE;
                  end
               end else if (char_data_i == ASCII_FF) begin
                  cx_d = '0;
                  cy_d = '0;
               end
               if (newline) begin
                  cx_d = '0;
                  if (cy_q != Y_LAST) cy_d = cy_q + 1'b1;
                  else                raddr_d = COLS_A;
               end
            end
         end
      endcase
      // Every sweep state starts its index from zero.
      if (state_d != state_q) idx_d = '0;
   end

   assign ready_d = (state_d == IDLE);

   cursor_blinker #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .restart_i (accept),
      .blink_o   (cursor_blink_o)
   );

   assign char_ready_o = ready_q;
   assign vram_we_o    = we_q;
   assign vram_waddr_o = waddr_q;
   assign vram_wdata_o = wdata_q;
   assign vram_raddr_o = raddr_q;
   assign cursor_x_o   = cx_q;
   assign cursor_y_o   = cy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a behavioural dual-port VRAM.
module tb_text_console_writer;
   import text_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [7:0]  cdata;
   logic        ready;
   logic        we;
   logic [11:0] waddr;
   logic [7:0]  wdata;
   logic [11:0] raddr;
   logic [7:0]  rdata;
   logic [6:0]  cx;
   logic [4:0]  cy;
   logic        blink;

   logic [7:0]  mem [0:2999];
   logic        preload;
   logic        mon_clr;
   int          wr_cnt;
   int          seq_err;
   int          passed = 0;
   int          total  = 0;
   int          errs   = 0;
   int          n;

   always #5 clk = ~clk;

   text_console_writer #(.BLINK_DIV(4)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .char_valid_i   (valid),
      .char_data_i    (cdata),
      .char_ready_o   (ready),
      .vram_we_o      (we),
      .vram_waddr_o   (waddr),
      .vram_wdata_o   (wdata),
      .vram_raddr_o   (raddr),
      .vram_rdata_i   (rdata),
      .cursor_x_o     (cx),
      .cursor_y_o     (cy),
      .cursor_blink_o (blink)
   );

   // VRAM model: registered read port, write port, optional row-pattern load
   always @(posedge clk) begin
      rdata <= mem[raddr];
      if (preload) begin
         for (int a = 0; a < 3000; a++) mem[a] <= 8'h30 + 8'((a / 100) % 10);
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Write counter; sequential-address check used during full clears
   always @(posedge clk) begin
      if (mon_clr) begin
         wr_cnt  <= 0;
         seq_err <= 0;
      end else if (we) begin
         wr_cnt <= wr_cnt + 1;
         if (waddr != 12'(wr_cnt)) seq_err <= seq_err + 1;
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      valid = 1'b1;
      cdata = b;
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   // Number of clock edges until char_ready is seen high (bounded)
   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!ready && cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   function automatic int count_space(input int lo, input int hi);
      int c = 0;
      for (int a = lo; a <= hi; a++) if (mem[a] === 8'h20) c++;
      return c;
   endfunction

   initial begin
      rst_n   = 1'b0;
      valid   = 1'b0;
      cdata   = 8'h00;
      preload = 1'b0;
      mon_clr = 1'b1;
      tick(2);
      chk("rst_ready", ready, 0);
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 8'h20);
      chk("rst_raddr", raddr, 0);
      chk("rst_cx", cx, 0);
      chk("rst_cy", cy, 0);
      chk("rst_blink", blink, 1);

      // Power-up clear
      rst_n   = 1'b1;
      mon_clr = 1'b0;
      wait_ready(n);
      chk("clear_cycles", n, 3000);
      tick(1);
      chk("clear_writes", wr_cnt, 3000);
      chk("clear_order", seq_err, 0);
      chk("clear_spaces", count_space(0, 2999), 3000);
      chk("clear_cx", cx, 0);
      chk("clear_cy", cy, 0);
      chk("idle_no_we", we, 0);

      // "AB" back to back
      send(8'h41);
      chk("A_we", we, 1);
      chk("A_addr", waddr, 0);
      chk("A_data", wdata, 8'h41);
      chk("A_cx", cx, 1);
      send(8'h42);
      chk("B_addr", waddr, 1);
      chk("B_data", wdata, 8'h42);
      chk("B_cx", cx, 2);
      chk("B_cy", cy, 0);
      chk("B_ready", ready, 1);
      tick(1);
      chk("idle_no_we2", we, 0);

      // Blink with a 4-cycle half-period; 1 edge already elapsed since 'B'
      tick(2);
      chk("blink_3", blink, 1);
      tick(1);
      chk("blink_4", blink, 0);
      tick(3);
      chk("blink_7", blink, 0);
      tick(1);
      chk("blink_8", blink, 1);
      tick(4);
      chk("blink_12", blink, 0);
      send(ASCII_CR);
      chk("blink_restart", blink, 1);
      chk("cr_cx", cx, 0);

      // Newlines then a full row of 'x' at row 5
      send(ASCII_LF);
      chk("lf_ready", ready, 1);
      chk("lf_cy", cy, 1);
      repeat (4) send(ASCII_LF);
      chk("row5_cy", cy, 5);
      repeat (100) send(8'h78);
      chk("x_last_addr", waddr, 599);
      chk("x_last_data", wdata, 8'h78);
      chk("x_wrap_cx", cx, 0);
      chk("x_wrap_cy", cy, 6);
      tick(1);
      chk("x_mem500", mem[500], 8'h78);

      // Form feed, then backspace cases
      send(ASCII_FF);
      chk("ff_ready", ready, 0);
      chk("ff_cy", cy, 0);
      wait_ready(n);
      chk("ff_cycles", n, 3000);
      tick(1);
      chk("ff_mem500", mem[500], 8'h20);
      send(ASCII_LF);
      send(ASCII_LF);
      send(8'h61);
      send(8'h62);
      send(8'h63);
      send(ASCII_BS);
      chk("bs_we", we, 1);
      chk("bs_addr", waddr, 202);
      chk("bs_data", wdata, 8'h20);
      chk("bs_cx", cx, 2);
      chk("bs_cy", cy, 2);
      send(ASCII_CR);
      send(ASCII_BS);
      chk("bs0_we", we, 0);
      chk("bs0_cx", cx, 0);
      chk("bs0_cy", cy, 2);

      // LF on the last row scrolls a preloaded pattern
      repeat (27) send(ASCII_LF);
      chk("row29_cy", cy, 29);
      preload = 1'b1;
      tick(1);
      preload = 1'b0;
      tick(1);
      send(ASCII_LF);
      chk("scr_ready", ready, 0);
      chk("scr_cy", cy, 29);
      chk("scr_cx", cx, 0);
      wait_ready(n);
      chk("scr_cycles", n, 3001);
      tick(1);
      chk("scr_mem0", mem[0], 8'h31);
      chk("scr_mem1500", mem[1500], 8'h36);
      chk("scr_mem2899", mem[2899], 8'h39);
      chk("scr_row29", count_space(2900, 2999), 100);
      chk("scr_cy_after", cy, 29);

      // Printable in the bottom-right cell: glyph first, then scroll
      repeat (99) send(8'h79);
      send(8'h7A);
      chk("br_we", we, 1);
      chk("br_addr", waddr, 2999);
      chk("br_data", wdata, 8'h7A);
      chk("br_ready", ready, 0);
      chk("br_cx", cx, 0);
      wait_ready(n);
      chk("br_cycles", n, 3001);
      tick(1);
      chk("br_mem2899", mem[2899], 8'h7A);
      chk("br_mem2800", mem[2800], 8'h79);
      chk("br_mem2999", mem[2999], 8'h20);

      // Reset in the middle of a scroll restarts the full clear
      send(ASCII_LF);
      tick(100);
      chk("mid_ready", ready, 0);
      rst_n   = 1'b0;
      mon_clr = 1'b1;
      #1;
      chk("mid_rst_we", we, 0);
      chk("mid_rst_raddr", raddr, 0);
      chk("mid_rst_waddr", waddr, 0);
      tick(2);
      rst_n   = 1'b1;
      mon_clr = 1'b0;
      wait_ready(n);
      chk("re_clear_cycles", n, 3000);
      tick(1);
      chk("re_clear_writes", wr_cnt, 3000);
      chk("re_clear_order", seq_err, 0);
      chk("re_clear_spaces", count_space(0, 2999), 3000);
      chk("re_clear_cy", cy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
